mem_arbiter: RTL and testbench

- Shares one single-port synchronous memory between the CPU core's instruction-fetch port and its load/store port.
- Serialises the two requesters with a small FSM. Data accesses have priority; a starvation guard forces fetch grants periodically.
- Returns read data and a one-cycle acknowledge to each requester. The core stalls on each port until that port's acknowledge arrives.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port synchronous memory between
// instruction fetch and load/store, with data priority and a fetch starvation guard.
module mem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int MEM_LAT        = 1,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam int SW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);
    localparam logic [2:0]    LAT_LOAD   = 3'(MEM_LAT - 1);

    logic [1:0]    state;
    logic          gnt_d;
    logic [2:0]    lat_cnt;
    logic [SW-1:0] streak;

    logic force_if;
    logic pick_d;
    logic any_req;

    // Fetch overrides data priority once the data streak has saturated.
    always_comb begin
        force_if = if_req && (streak == STREAK_MAX);
        pick_d   = d_req && !force_if;
        any_req  = d_req || if_req;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            gnt_d     <= 1'b0;
            lat_cnt   <= 3'd0;
            streak    <= '0;
            if_rdata  <= '0;
            if_ack    <= 1'b0;
            d_rdata   <= '0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            mem_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_d  <= pick_d;
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                        if (pick_d) begin
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            if (if_req && (streak != STREAK_MAX))
                                streak <= streak + SW'(1);
                            else if (!if_req)
                                streak <= '0;
                        end else begin
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                            streak   <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        d_ack  <= gnt_d;
                        if_ack <= !gnt_d;
                        state  <= ACK;
                    end else begin
                        lat_cnt <= LAT_LOAD;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        if (gnt_d) begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ack   <= 1'b1;
                        end
                        state <= ACK;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    logic        a_if_req = 0, a_d_req = 0, a_d_we = 0;
    logic [31:0] a_if_addr = 0, a_d_addr = 0, a_d_wdata = 0;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_if_ack, a_d_ack, a_mem_en, a_mem_we, a_busy;

    logic        b_if_req = 0, b_d_req = 0, b_d_we = 0;
    logic [31:0] b_if_addr = 0, b_d_addr = 0, b_d_wdata = 0;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_ack, b_d_ack, b_mem_en, b_mem_we, b_busy;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_DATA_BURST(4)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_rdata(a_d_rdata), .d_ack(a_d_ack),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_DATA_BURST(4)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] lookup(input logic [31:0] addr);
        case (addr)
            32'h100: lookup = 32'h0000_0013;
            32'h40:  lookup = 32'hCAFE_F00D;
            32'h8:   lookup = 32'h0000_0001;
            32'h200: lookup = 32'h0000_2222;
            32'h300: lookup = 32'h0000_3333;
            default: lookup = addr ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory models: read data is valid only MEM_LAT cycles after the mem_en cycle.
    logic [31:0] pipe_a;
    logic [31:0] pipe_b [3];
    always @(posedge clk) begin
        pipe_a    <= (a_mem_en && !a_mem_we) ? lookup(a_mem_addr) : 32'hDEAD_0BAD;
        pipe_b[0] <= (b_mem_en && !b_mem_we) ? lookup(b_mem_addr) : 32'hDEAD_0BAD;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign a_mem_rdata = pipe_a;
    assign b_mem_rdata = pipe_b[2];

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while ((a_busy !== 1'b0) && (k < 20)) begin
            step();
            k++;
        end
        total++;
        if (a_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_timeout_a got busy=%b want 0", a_busy);
        end
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(3);
        total++;
        if ({a_mem_en, a_mem_we, a_if_ack, a_d_ack, a_busy} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl_a got %b want 00000", {a_mem_en, a_mem_we, a_if_ack, a_d_ack, a_busy});
        end
        total++;
        if ({a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata} !== 128'b0) begin
            bad++;
            $display("[TB] FAIL reset_data_a got %h want 0", {a_mem_addr, a_mem_wdata, a_if_rdata, a_d_rdata});
        end
        total++;
        if ({b_mem_en, b_busy, b_if_ack, b_d_ack, b_mem_addr} !== 36'b0) begin
            bad++;
            $display("[TB] FAIL reset_b got %h want 0", {b_mem_en, b_busy, b_if_ack, b_d_ack, b_mem_addr});
        end
        reset = 1'b1;
        step(2);
    endtask

    task automatic test_fetch();
        a_if_req = 1'b1;
        a_if_addr = 32'h100;
        step();
        total++;
        if ({a_mem_en, a_mem_we, a_mem_addr, a_busy} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
            bad++;
            $display("[TB] FAIL fetch_issue got en=%b we=%b addr=%h busy=%b want 1 0 100 1", a_mem_en, a_mem_we, a_mem_addr, a_busy);
        end
        step();
        total++;
        if ({a_mem_en, a_if_ack, a_busy} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL fetch_wait got en=%b ack=%b busy=%b want 0 0 1", a_mem_en, a_if_ack, a_busy);
        end
        step();
        total++;
        if ({a_if_ack, a_d_ack, a_busy, a_if_rdata} !== {3'b101, 32'h13}) begin
            bad++;
            $display("[TB] FAIL fetch_ack got ack=%b dack=%b busy=%b rdata=%h want 1 0 1 00000013", a_if_ack, a_d_ack, a_busy, a_if_rdata);
        end
        a_if_req = 1'b0;
        step();
        total++;
        if ({a_if_ack, a_busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL fetch_done got ack=%b busy=%b want 0 0", a_if_ack, a_busy);
        end
        step();
    endtask

    task automatic test_store();
        a_d_req = 1'b1;
        a_d_we = 1'b1;
        a_d_addr = 32'h2000;
        a_d_wdata = 32'hDEAD_BEEF;
        step();
        total++;
        if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {2'b11, 32'h2000, 32'hDEAD_BEEF}) begin
            bad++;
            $display("[TB] FAIL store_issue got en=%b we=%b addr=%h wdata=%h want 1 1 2000 deadbeef", a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
        end
        step();
        total++;
        if ({a_d_ack, a_if_ack, a_d_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("[TB] FAIL store_ack got dack=%b iack=%b rdata=%h want 1 0 00000000", a_d_ack, a_if_ack, a_d_rdata);
        end
        a_d_req = 1'b0;
        a_d_we = 1'b0;
        step();
        total++;
        if ({a_mem_en, a_mem_we, a_mem_addr, a_d_ack, a_busy} !== {2'b01, 32'h2000, 2'b00}) begin
            bad++;
            $display("[TB] FAIL store_hold got en=%b we=%b addr=%h dack=%b busy=%b want 0 1 2000 0 0", a_mem_en, a_mem_we, a_mem_addr, a_d_ack, a_busy);
        end
        step();
    endtask

    task automatic test_both();
        a_d_req = 1'b1;
        a_d_we = 1'b0;
        a_d_addr = 32'h40;
        a_if_req = 1'b1;
        a_if_addr = 32'h8;
        step();
        total++;
        if ({a_mem_en, a_mem_addr} !== {1'b1, 32'h40}) begin
            bad++;
            $display("[TB] FAIL both_first_grant got en=%b addr=%h want 1 40", a_mem_en, a_mem_addr);
        end
        step(2);
        total++;
        if ({a_d_ack, a_if_ack, a_d_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
            bad++;
            $display("[TB] FAIL both_dack got dack=%b iack=%b rdata=%h want 1 0 cafef00d", a_d_ack, a_if_ack, a_d_rdata);
        end
        total++;
        if (a_if_rdata !== 32'h13) begin
            bad++;
            $display("[TB] FAIL both_if_hold got %h want 00000013", a_if_rdata);
        end
        a_d_req = 1'b0;
        step(2);
        total++;
        if ({a_mem_en, a_mem_addr} !== {1'b1, 32'h8}) begin
            bad++;
            $display("[TB] FAIL both_second_grant got en=%b addr=%h want 1 8", a_mem_en, a_mem_addr);
        end
        step(2);
        total++;
        if ({a_if_ack, a_d_ack, a_if_rdata, a_d_rdata} !== {2'b10, 32'h1, 32'hCAFE_F00D}) begin
            bad++;
            $display("[TB] FAIL both_iack got iack=%b dack=%b ir=%h dr=%h want 1 0 1 cafef00d", a_if_ack, a_d_ack, a_if_rdata, a_d_rdata);
        end
        a_if_req = 1'b0;
        wait_idle_a();
    endtask

    task automatic test_starve();
        string got = "";
        string exp = "DDDDFD";
        int cyc = 0;
        int both_ack = 0;
        a_d_req = 1'b1;
        a_d_we = 1'b0;
        a_d_addr = 32'h300;
        a_if_req = 1'b1;
        a_if_addr = 32'h200;
        while ((got.len() < 6) && (cyc < 80)) begin
            step();
            cyc++;
            if (a_if_ack && a_d_ack) both_ack++;
            if (a_mem_en) got = {got, (a_mem_addr == 32'h300) ? "D" : "F"};
        end
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL starve_order got %s want %s", got, exp);
        end
        total++;
        if (both_ack != 0) begin
            bad++;
            $display("[TB] FAIL dual_ack got %0d cycles want 0", both_ack);
        end
        total++;
        if ({a_if_rdata, a_d_rdata} !== {32'h2222, 32'h3333}) begin
            bad++;
            $display("[TB] FAIL starve_data got ir=%h dr=%h want 00002222 00003333", a_if_rdata, a_d_rdata);
        end
        a_d_req = 1'b0;
        a_if_req = 1'b0;
        wait_idle_a();
    endtask

    task automatic test_lat3();
        b_d_req = 1'b1;
        b_d_we = 1'b0;
        b_d_addr = 32'h40;
        step();
        total++;
        if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h40}) begin
            bad++;
            $display("[TB] FAIL lat3_issue got en=%b addr=%h want 1 40", b_mem_en, b_mem_addr);
        end
        step(3);
        total++;
        if ({b_d_ack, b_busy} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL lat3_early got dack=%b busy=%b want 0 1", b_d_ack, b_busy);
        end
        step();
        total++;
        if ({b_d_ack, b_d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            bad++;
            $display("[TB] FAIL lat3_ack got dack=%b rdata=%h want 1 cafef00d", b_d_ack, b_d_rdata);
        end
        b_d_req = 1'b0;
        step();
        total++;
        if ({b_d_ack, b_busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL lat3_done got dack=%b busy=%b want 0 0", b_d_ack, b_busy);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int late_ack = 0;
        b_d_req = 1'b1;
        b_d_we = 1'b0;
        b_d_addr = 32'h100;
        step(2);
        reset = 1'b0;
        b_d_req = 1'b0;
        step();
        total++;
        if ({b_mem_en, b_mem_we, b_if_ack, b_d_ack, b_busy} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_ctrl got %b want 00000", {b_mem_en, b_mem_we, b_if_ack, b_d_ack, b_busy});
        end
        total++;
        if ({b_mem_addr, b_mem_wdata, b_if_rdata, b_d_rdata} !== 128'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_data got %h want 0", {b_mem_addr, b_mem_wdata, b_if_rdata, b_d_rdata});
        end
        reset = 1'b1;
        repeat (5) begin
            step();
            if (b_d_ack || b_busy) late_ack++;
        end
        total++;
        if ((late_ack != 0) || (b_d_rdata !== 32'h0)) begin
            bad++;
            $display("[TB] FAIL rst_mid_late got activity=%0d rdata=%h want 0 00000000", late_ack, b_d_rdata);
        end
        b_if_req = 1'b1;
        b_if_addr = 32'h8;
        step();
        total++;
        if ({b_mem_en, b_mem_addr} !== {1'b1, 32'h8}) begin
            bad++;
            $display("[TB] FAIL rst_fetch_issue got en=%b addr=%h want 1 8", b_mem_en, b_mem_addr);
        end
        step(3);
        total++;
        if (b_if_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_fetch_early got %b want 0", b_if_ack);
        end
        step();
        total++;
        if ({b_if_ack, b_if_rdata} !== {1'b1, 32'h1}) begin
            bad++;
            $display("[TB] FAIL rst_fetch_ack got ack=%b rdata=%h want 1 00000001", b_if_ack, b_if_rdata);
        end
        b_if_req = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_both();
        test_starve();
        test_lat3();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
